// File: rtl/ysyx_22041207_pipe_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, EX redirect flushes,
// and a memory-wait FSM that freezes the pipe while a data access is outstanding.
module ysyx_22041207_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_load,
    input  logic [4:0]       ex_rwaddr,
    input  logic             ex_redirect,
    input  logic             me_mem_req,
    input  logic             dmem_ack,
    output logic             pc_hold,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_me_stall,
    output logic             me_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_redirect,
    output logic [CNT_W-1:0] cnt_memwait
);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        timeout_hit;
    logic        lu;
    logic        ms;
    logic        redirect_act;
    logic        loaduse_act;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard
    assign lu = ex_load && (ex_rwaddr != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rwaddr)) ||
                 (id_use_rs2 && (id_rs2 == ex_rwaddr)));

    assign ms = (state == MEM_WAIT) || (me_mem_req && !dmem_ack);
    assign redirect_act = !ms && ex_redirect;
    assign loaduse_act  = !ms && !ex_redirect && lu;

    always_comb begin
        pc_hold      = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_me_stall  = 1'b0;
        me_wb_bubble = 1'b0;
        if (ms) begin
            pc_hold      = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_me_stall  = 1'b1;
            me_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu) begin
            pc_hold      = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    // The counter includes the IDLE cycle that launched the wait, hence the +1 look-ahead
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        timeout_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (me_mem_req && !dmem_ack) begin
                    next_state    = MEM_WAIT;
                    wait_cnt_next = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    next_state    = IDLE;
                    wait_cnt_next = 16'd0;
                end else if (({1'b0, wait_cnt} + 17'd1) >= 17'(MEM_TIMEOUT)) begin
                    next_state    = IDLE;
                    wait_cnt_next = 16'd0;
                    timeout_hit   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 16'd1;
                end
            end
            default: begin
                next_state    = IDLE;
                wait_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout  <= 1'b0;
            cnt_loaduse  <= '0;
            cnt_redirect <= '0;
            cnt_memwait  <= '0;
        end else begin
            if (timeout_hit) mem_timeout <= 1'b1;
            if (ms && (cnt_memwait != '1)) cnt_memwait <= cnt_memwait + CNT_W'(1);
            if (redirect_act && (cnt_redirect != '1)) cnt_redirect <= cnt_redirect + CNT_W'(1);
            if (loaduse_act && (cnt_loaduse != '1)) cnt_loaduse <= cnt_loaduse + CNT_W'(1);
        end
    end

endmodule

// File: doc/ysyx_22041207_pipe_ctrl.md
Name: ysyx_22041207_pipe_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/ME, ME/WB).
- Generates per-register hold (stall) and clear (bubble/flush) controls.
- Detects load-use hazards and control redirects resolved in EX.
- Runs a memory-wait FSM that freezes the pipe while a data-memory access in ME is outstanding, and keeps saturating performance counters for each stall class.

Parameters:
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before error abort; valid range 1..65535
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock; FSM state and counters update on posedge
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 address of the instruction in ID
- id_rs2  in  5  rs2 address of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_load  in  1  EX holds a load (memoryReadWen)
- ex_rwaddr  in  5  EX destination register
- ex_redirect  in  1  EX resolved taken branch, jal or jalr
- me_mem_req  in  1  ME issues a data-memory access this cycle
- dmem_ack  in  1  data memory completes the access
- pc_hold  out  1  PC keeps its value
- if_id_stall  out  1  IF/ID holds
- if_id_flush  out  1  IF/ID clears
- id_ex_stall  out  1  ID/EX holds
- id_ex_bubble  out  1  ID/EX clears
- ex_me_stall  out  1  EX/ME holds
- me_wb_bubble  out  1  ME/WB clears
- mem_timeout  out  1  sticky error flag
- cnt_loaduse  out  CNT_W  load-use stall cycles
- cnt_redirect  out  CNT_W  redirect flush events
- cnt_memwait  out  CNT_W  memory-wait cycles

Behaviour:
- States: IDLE, MEM_WAIT. State register and wait counter are on posedge clk.
- Control outputs are combinational from state and inputs. They must settle during the clock-high phase, because the pipeline registers capture on negedge.
- Reset (rst=1 at posedge):
  - state=IDLE, wait counter=0.
  - mem_timeout=0 and all counters=0.
  - All control outputs are 0 while in IDLE with idle inputs.
- Load-use hazard, defined as lu:
  - ex_load=1, ex_rwaddr!=0, and ((id_use_rs1 and id_rs1==ex_rwaddr) or (id_use_rs2 and id_rs2==ex_rwaddr)).
  - Register x0 never causes a hazard.
- Memory stall, defined as ms: state==MEM_WAIT, or (state==IDLE and me_mem_req=1 and dmem_ack=0).
- Output priority is ms > ex_redirect > lu.
  - ms:
    - pc_hold=if_id_stall=id_ex_stall=ex_me_stall=1, me_wb_bubble=1.
    - The redirect is ignored; EX is frozen, so it re-presents the redirect after the stall.
    - lu is ignored.
  - ex_redirect (no ms): if_id_flush=1, id_ex_bubble=1, no holds. Flush wins over any concurrent lu.
  - lu (no ms, no redirect): pc_hold=if_id_stall=1, id_ex_bubble=1. Exactly one cycle per hazard instance.
- FSM transitions:
  - IDLE -> MEM_WAIT when me_mem_req=1 and dmem_ack=0. The wait counter loads 1.
  - Single-cycle access (me_mem_req=1, dmem_ack=1 in IDLE) causes no stall and stays in IDLE.
  - MEM_WAIT while dmem_ack=0:
    - The wait counter increments.
    - When the counter reaches MEM_TIMEOUT: set mem_timeout, return to IDLE, counter=0.
  - MEM_WAIT with dmem_ack=1: the freeze is still asserted in this cycle; next state is IDLE and the counter clears.
  - me_mem_req is don't-care in MEM_WAIT.
- mem_timeout stays set until rst.
- Counters, each saturating at all-ones and updated on posedge:
  - cnt_memwait: +1 per cycle with ms=1.
  - cnt_redirect: +1 per cycle with redirect outputs active.
  - cnt_loaduse: +1 per cycle with lu outputs active.
- rst asserted during MEM_WAIT aborts the wait immediately. Outputs are idle from the next cycle.

Test Plan:
- Load-use: ex_load=1, ex_rwaddr=5, id_rs2=5, id_use_rs2=1 -> pc_hold=if_id_stall=id_ex_bubble=1 for 1 cycle; cnt_loaduse=1. Repeat with ex_rwaddr=0 -> no stall.
- Redirect plus hazard: ex_redirect=1 together with the load-use condition above -> if_id_flush=id_ex_bubble=1, pc_hold=0; cnt_redirect=1, cnt_loaduse=0.
- Memory wait: me_mem_req=1, dmem_ack held low 3 cycles then high -> 4 cycles of full freeze with me_wb_bubble=1, then IDLE; cnt_memwait=4. Holding ex_redirect=1 throughout -> the flush is asserted only after the freeze ends.
- Zero-wait access: me_mem_req=1, dmem_ack=1 in the same cycle -> no outputs asserted, state stays IDLE.
- Timeout: MEM_TIMEOUT=4, dmem_ack never asserted -> mem_timeout=1 after 4 wait cycles, back in IDLE; flag persists until rst.
- Reset mid-wait: rst pulsed in the 2nd MEM_WAIT cycle -> state=IDLE, counters=0, all outputs 0 the following cycle.
